fetch_stage: RTL and testbench

Dual-issue instruction fetch stage that directly feeds the IF/ID pipeline register. Holds the architectural fetch PC and reads two consecutive 16-bit instructions per cycle from a two-port asynchronous-read instruction memory. A small direct-mapped BTB with 2-bit saturating counters predicts taken branches per slot. Execute-stage redirects override all other next-PC sources.

---
 rtl/fetch_stage_if.sv | 33 +++
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: execute-side control and BTB update, instruction memory
// read ports, and the two fetched slots handed to the IF/ID register.
interface fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        upd_en;
  logic [15:0] upd_pc;
  logic [15:0] upd_target;
  logic        upd_taken;
  logic [15:0] imem_addr1, imem_addr2;
  logic [15:0] imem_data1, imem_data2;
  logic [15:0] I1, I2;
  logic        I1V, I2V;
  logic        I1P, I2P;
  logic [15:0] I1PC, I2PC;

  modport slave (
    input  stall, redirect, redirect_pc,
    input  upd_en, upd_pc, upd_target, upd_taken,
    output imem_addr1, imem_addr2,
    input  imem_data1, imem_data2,
    output I1, I2, I1V, I2V, I1P, I2P, I1PC, I2PC
  );

  modport master (
    output stall, redirect, redirect_pc,
    output upd_en, upd_pc, upd_target, upd_taken,
    input  imem_addr1, imem_addr2,
    output imem_data1, imem_data2,
    input  I1, I2, I1V, I2V, I1P, I2P, I1PC, I2PC
  );
endinterface

// File: rtl/fetch_stage.sv
// Dual-issue fetch: PC register, two-slot instruction read, and a direct-mapped
// BTB with 2-bit counters (two read ports, one write port).

module fetch_btb_rd #(
  parameter int IDX_W   = 4,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 11
) (
  input  logic [IDX_W-1:0]                idx,
  input  logic [TAG_W-1:0]                tag,
  input  logic [ENTRIES-1:0]              vld,
  input  logic [ENTRIES-1:0][TAG_W-1:0]   tags,
  input  logic [ENTRIES-1:0][15:0]        tgts,
  input  logic [ENTRIES-1:0][1:0]         ctrs,
  output logic                            taken,
  output logic [15:0]                     target
);
  logic hit;
  assign hit    = vld[idx] && (tags[idx] == tag);
  assign taken  = hit && ctrs[idx][1];
  assign target = tgts[idx];
endmodule

module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BTB_IDX_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  fif
);
  localparam int NUM_SLOTS = 2;
  localparam int ENTRIES   = 2 ** BTB_IDX_W;
  localparam int TAG_W     = 15 - BTB_IDX_W;

  logic [15:0]                   pc_q, pc_d;
  logic [ENTRIES-1:0]            vld_q, vld_d;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][15:0]      tgt_q, tgt_d;
  logic [ENTRIES-1:0][1:0]       ctr_q, ctr_d;

  logic [NUM_SLOTS-1:0][15:0]    slot_pc, slot_tgt;
  logic [NUM_SLOTS-1:0]          slot_tkn;
  logic                          p1, p2, out_ok;

  assign slot_pc[0] = pc_q;
  assign slot_pc[1] = pc_q + 16'd2;

  // Each slot gets its own read port; adjacent PCs never share an index.
  generate
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_rd
      fetch_btb_rd #(
        .IDX_W   (BTB_IDX_W),
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W)
      ) u_rd (
        .idx    (slot_pc[s][BTB_IDX_W:1]),
        .tag    (slot_pc[s][15:BTB_IDX_W+1]),
        .vld    (vld_q),
        .tags   (tag_q),
        .tgts   (tgt_q),
        .ctrs   (ctr_q),
        .taken  (slot_tkn[s]),
        .target (slot_tgt[s])
      );
    end
  endgenerate

  assign p1     = slot_tkn[0];
  assign p2     = !p1 && slot_tkn[1];
  assign out_ok = !reset && !fif.redirect;

  assign fif.imem_addr1 = slot_pc[0];
  assign fif.imem_addr2 = slot_pc[1];
  assign fif.I1         = fif.imem_data1;
  assign fif.I2         = fif.imem_data2;
  assign fif.I1PC       = slot_pc[0];
  assign fif.I2PC       = slot_pc[1];
  assign fif.I1V        = out_ok;
  assign fif.I2V        = out_ok && !p1;
  assign fif.I1P        = out_ok && p1;
  assign fif.I2P        = out_ok && p2;

  always_comb begin
    pc_d = pc_q;
    if (fif.redirect)  pc_d = {fif.redirect_pc[15:1], 1'b0};
    else if (fif.stall) pc_d = pc_q;
    else if (p1)        pc_d = slot_tgt[0];
    else if (p2)        pc_d = slot_tgt[1];
    else                pc_d = pc_q + 16'd4;
  end

  logic [BTB_IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0]     upd_tag;
  logic                 upd_hit;
  logic                 unused_bits;

  assign upd_idx     = fif.upd_pc[BTB_IDX_W:1];
  assign upd_tag     = fif.upd_pc[15:BTB_IDX_W+1];
  assign upd_hit     = vld_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign unused_bits = ^{fif.redirect_pc[0], fif.upd_pc[0], fif.upd_target[0]};

  // Writes land at the edge, so same-cycle lookups see the old entry.
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    ctr_d = ctr_q;
    if (fif.upd_en) begin
      if (upd_hit) begin
        if (fif.upd_taken) begin
          ctr_d[upd_idx] = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01;
          tgt_d[upd_idx] = {fif.upd_target[15:1], 1'b0};
        end else begin
          ctr_d[upd_idx] = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01;
        end
      end else if (fif.upd_taken) begin
        vld_d[upd_idx] = 1'b1;
        tag_d[upd_idx] = upd_tag;
        tgt_d[upd_idx] = {fif.upd_target[15:1], 1'b0};
        ctr_d[upd_idx] = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      vld_q <= '0;
      tag_q <= '0;
      tgt_q <= '0;
      ctr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      vld_q <= vld_d;
      tag_q <= tag_d;
      tgt_q <= tgt_d;
      ctr_q <= ctr_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequencing, stall, redirect, BTB training,
// counter saturation, PC wrap, same-cycle update hazard and async reset.
module tb_fetch_stage;
  logic clk;
  logic reset;
  int   checks;
  int   fails;

  fetch_stage_if fif ();

  fetch_stage #(.RESET_PC(16'h0000), .BTB_IDX_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .fif   (fif.slave)
  );

  assign fif.imem_data1 = fif.imem_addr1 ^ 16'h5A5A;
  assign fif.imem_data2 = fif.imem_addr2 ^ 16'h5A5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic redir(input logic [15:0] pc);
    fif.redirect    = 1'b1;
    fif.redirect_pc = pc;
    step();
    fif.redirect    = 1'b0;
    #1;
  endtask

  task automatic upd(input logic [15:0] pc, input logic tkn, input logic [15:0] tgt);
    fif.upd_en     = 1'b1;
    fif.upd_pc     = pc;
    fif.upd_taken  = tkn;
    fif.upd_target = tgt;
    step();
    fif.upd_en     = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    fif.stall = 1'b0; fif.redirect = 1'b0; fif.redirect_pc = '0;
    fif.upd_en = 1'b0; fif.upd_pc = '0; fif.upd_target = '0; fif.upd_taken = 1'b0;
    #1;
    chk("rst_i1v", 16'(fif.I1V), 16'h0);
    chk("rst_pc", fif.I1PC, 16'h0000);

    step(); reset = 1'b0; #1;
    chk("seq0_pc1", fif.I1PC, 16'h0000);
    chk("seq0_pc2", fif.I2PC, 16'h0002);
    chk("seq0_vld", {14'h0, fif.I1V, fif.I2V}, 16'h3);
    chk("seq0_prd", {14'h0, fif.I1P, fif.I2P}, 16'h0);
    chk("seq0_i1", fif.I1, 16'h5A5A);
    chk("seq0_i2", fif.I2, 16'h5A58);
    step(); #1;
    chk("seq1_pc1", fif.I1PC, 16'h0004);
    chk("seq1_pc2", fif.I2PC, 16'h0006);
    step(); #1;
    chk("seq2_pc1", fif.I1PC, 16'h0008);
    chk("seq2_pc2", fif.I2PC, 16'h000A);

    fif.stall = 1'b1; #1;
    chk("stall0_pc1", fif.I1PC, 16'h0008);
    step(); #1;
    chk("stall1_pc1", fif.I1PC, 16'h0008);
    chk("stall1_pc2", fif.I2PC, 16'h000A);
    step(); #1;
    chk("stall2_pc1", fif.I1PC, 16'h0008);
    fif.stall = 1'b0;
    step(); #1;
    chk("unstall_pc1", fif.I1PC, 16'h000C);

    fif.redirect = 1'b1; fif.redirect_pc = 16'h0041; fif.stall = 1'b1; #1;
    chk("redir_vld", {14'h0, fif.I1V, fif.I2V}, 16'h0);
    chk("redir_prd", {14'h0, fif.I1P, fif.I2P}, 16'h0);
    step(); fif.redirect = 1'b0; fif.stall = 1'b0; #1;
    chk("redir_pc1", fif.I1PC, 16'h0040);
    chk("redir_pc2", fif.I2PC, 16'h0042);

    upd(16'h0010, 1'b1, 16'h0080);
    redir(16'h0010);
    chk("s1tk_i1p", 16'(fif.I1P), 16'h1);
    chk("s1tk_i2v", 16'(fif.I2V), 16'h0);
    chk("s1tk_i2p", 16'(fif.I2P), 16'h0);
    step(); #1;
    chk("s1tk_tgt", fif.I1PC, 16'h0080);

    upd(16'h0010, 1'b1, 16'h0080);
    upd(16'h0010, 1'b1, 16'h0080);
    upd(16'h0010, 1'b1, 16'h0080);
    upd(16'h0010, 1'b0, 16'h0000);
    redir(16'h0010);
    chk("sat_ctr2_i1p", 16'(fif.I1P), 16'h1);
    step(); #1;
    chk("sat_ctr2_tgt", fif.I1PC, 16'h0080);
    upd(16'h0010, 1'b0, 16'h0000);
    redir(16'h0010);
    chk("ctr1_i1p", 16'(fif.I1P), 16'h0);
    chk("ctr1_i2v", 16'(fif.I2V), 16'h1);
    step(); #1;
    chk("ctr1_next", fif.I1PC, 16'h0014);

    upd(16'h0013, 1'b1, 16'h0090);
    redir(16'h0010);
    chk("s2tk_i1p", 16'(fif.I1P), 16'h0);
    chk("s2tk_i2p", 16'(fif.I2P), 16'h1);
    chk("s2tk_i2v", 16'(fif.I2V), 16'h1);
    step(); #1;
    chk("s2tk_tgt", fif.I1PC, 16'h0090);

    redir(16'h0010);
    fif.stall = 1'b1;
    fif.upd_en = 1'b1; fif.upd_pc = 16'h0010; fif.upd_taken = 1'b1; fif.upd_target = 16'h00A0;
    #1;
    chk("haz_old_i1p", 16'(fif.I1P), 16'h0);
    chk("haz_old_i2p", 16'(fif.I2P), 16'h1);
    step(); fif.upd_en = 1'b0; #1;
    chk("haz_new_i1p", 16'(fif.I1P), 16'h1);
    chk("haz_new_i2v", 16'(fif.I2V), 16'h0);
    fif.stall = 1'b0;
    step(); #1;
    chk("haz_new_tgt", fif.I1PC, 16'h00A0);

    redir(16'hFFFE);
    chk("wrap_pc1", fif.I1PC, 16'hFFFE);
    chk("wrap_pc2", fif.I2PC, 16'h0000);
    step(); #1;
    chk("wrap_next", fif.I1PC, 16'h0002);

    #2 reset = 1'b1; #1;
    chk("arst_pc", fif.I1PC, 16'h0000);
    chk("arst_vld", {14'h0, fif.I1V, fif.I2V}, 16'h0);
    step(); reset = 1'b0; #1;
    chk("arst_rel_pc", fif.I1PC, 16'h0000);
    chk("arst_rel_v", 16'(fif.I1V), 16'h1);
    redir(16'h0010);
    chk("arst_btb_p", {14'h0, fif.I1P, fif.I2P}, 16'h0);
    step(); #1;
    chk("arst_btb_nx", fif.I1PC, 16'h0014);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
